// File: rtl/risc_v_pkg.sv
// risc_v_pkg: response FSM state enum and data width shared by the memory port arbiter
package risc_v_pkg;
  localparam int DataWidth = 32;
  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} resp_state_e;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating count of denied fetch cycles; wait_i counts, clear_i zeroes, sat_o flags MaxStarve
module arb_starve_cnt #(
  parameter int MaxStarve = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wait_i,
  input  logic clear_i,
  output logic sat_o
);
  localparam int CW = $clog2(MaxStarve + 1);
  logic [CW-1:0] cnt;
  assign sat_o = cnt == CW'(MaxStarve);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt <= '0;
    else if (clear_i) cnt <= '0;
    else if (wait_i && !sat_o) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (if_*) and load/store (d_*) with starvation override; mem_* is the shared port, stall_o flags any ungranted request
module mem_port_arbiter
  import risc_v_pkg::*;
#(
  parameter int AddressWidth = 10,
  parameter int MaxStarve = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    if_req_i,
  input  logic [AddressWidth-1:0] if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DataWidth-1:0]    if_rdata_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [3:0]              d_be_i,
  input  logic [AddressWidth-1:0] d_addr_i,
  input  logic [DataWidth-1:0]    d_wdata_i,
  output logic                    d_gnt_o,
  output logic                    d_rvalid_o,
  output logic [DataWidth-1:0]    d_rdata_o,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [3:0]              mem_be_o,
  output logic [AddressWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  input  logic [DataWidth-1:0]    mem_rdata_i,
  output logic                    stall_o
);
  resp_state_e state_q, state_d;
  logic we_q, sat;
  arb_starve_cnt #(.MaxStarve(MaxStarve)) u_starve (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wait_i  (if_req_i & ~if_gnt_o),
    .clear_i (if_gnt_o | ~if_req_i),
    .sat_o   (sat)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q <= d_gnt_o & d_we_i;
    end
  // Grants are gated by rst_ni so the port goes quiet the instant reset asserts.
  always_comb begin
    d_gnt_o = rst_ni & d_req_i & ~(if_req_i & sat);
    if_gnt_o = rst_ni & if_req_i & ~d_gnt_o;
    state_d = if_gnt_o ? RESP_IF : d_gnt_o ? RESP_D : IDLE;
    mem_en_o = if_gnt_o | d_gnt_o;
    mem_we_o = d_gnt_o & d_we_i;
    mem_be_o = d_gnt_o ? d_be_i : 4'b0;
    mem_addr_o = d_gnt_o ? d_addr_i : if_addr_i;
    mem_wdata_o = d_gnt_o ? d_wdata_i : '0;
    stall_o = (if_req_i & ~if_gnt_o) | (d_req_i & ~d_gnt_o);
    if_rvalid_o = state_q == RESP_IF;
    d_rvalid_o = state_q == RESP_D;
    if_rdata_o = if_rvalid_o ? mem_rdata_i : '0;
    d_rdata_o = d_rvalid_o && !we_q ? mem_rdata_i : '0;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random stimulus against a cycle-level reference model of the arbiter
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int MAX = 4;
  logic clk_i = 0, rst_ni = 0;
  logic if_req_i = 0, d_req_i = 0, d_we_i = 0;
  logic [AW-1:0] if_addr_i = 0, d_addr_i = 0;
  logic [3:0] d_be_i = 0;
  logic [31:0] d_wdata_i = 0, mem_rdata_i = 0;
  logic if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_en_o, mem_we_o, stall_o;
  logic [31:0] if_rdata_o, d_rdata_o, mem_wdata_o;
  logic [3:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  int checks = 0, failures = 0;
  int starve = 0;
  int resp = 0;
  bit resp_we = 0;

  mem_port_arbiter #(.AddressWidth(AW), .MaxStarve(MAX)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive after the falling edge, check settled outputs,
  // then advance the model across the rising edge.
  task automatic cycle(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dwe,
                       input logic [3:0] dbe, input logic [AW-1:0] da, input logic [31:0] dwd,
                       input logic [31:0] rd);
    bit g_if, g_d;
    if_req_i = ir; if_addr_i = ia; d_req_i = dr; d_we_i = dwe;
    d_be_i = dbe; d_addr_i = da; d_wdata_i = dwd; mem_rdata_i = rd;
    g_if = ir && (!dr || starve == MAX);
    g_d = dr && !g_if;
    #1;
    chk("if_gnt", {31'b0, if_gnt_o}, {31'b0, g_if});
    chk("d_gnt", {31'b0, d_gnt_o}, {31'b0, g_d});
    chk("mem_en", {31'b0, mem_en_o}, {31'b0, g_if || g_d});
    chk("mem_we", {31'b0, mem_we_o}, {31'b0, g_d && dwe});
    chk("mem_be", {28'b0, mem_be_o}, g_d ? {28'b0, dbe} : 32'b0);
    if (g_if || g_d) chk("mem_addr", {22'b0, mem_addr_o}, {22'b0, g_d ? da : ia});
    if (g_d) chk("mem_wdata", mem_wdata_o, dwd);
    chk("stall", {31'b0, stall_o}, {31'b0, (ir && !g_if) || (dr && !g_d)});
    chk("if_rvalid", {31'b0, if_rvalid_o}, {31'b0, resp == 1});
    chk("if_rdata", if_rdata_o, resp == 1 ? rd : 32'b0);
    chk("d_rvalid", {31'b0, d_rvalid_o}, {31'b0, resp == 2});
    chk("d_rdata", d_rdata_o, (resp == 2 && !resp_we) ? rd : 32'b0);
    @(posedge clk_i);
    starve = (ir && !g_if) ? (starve < MAX ? starve + 1 : MAX) : 0;
    resp = g_if ? 1 : g_d ? 2 : 0;
    resp_we = g_d && dwe;
    @(negedge clk_i);
  endtask

  task automatic idle(input logic [31:0] rd);
    cycle(0, 0, 0, 0, 0, 0, 0, rd);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_if_gnt"}, {31'b0, if_gnt_o}, 0);
    chk({tag, "_d_gnt"}, {31'b0, d_gnt_o}, 0);
    chk({tag, "_mem_en"}, {31'b0, mem_en_o}, 0);
    chk({tag, "_if_rvalid"}, {31'b0, if_rvalid_o}, 0);
    chk({tag, "_d_rvalid"}, {31'b0, d_rvalid_o}, 0);
    chk({tag, "_if_rdata"}, if_rdata_o, 0);
    chk({tag, "_d_rdata"}, d_rdata_o, 0);
  endtask

  initial begin
    mem_rdata_i = 32'hA5A5_5A5A;
    if_req_i = 1; d_req_i = 1;
    repeat (2) @(negedge clk_i);
    #1 chk_reset_outputs("reset");
    if_req_i = 0; d_req_i = 0;
    @(negedge clk_i);
    rst_ni = 1;
    idle(32'h1234_5678);
    // fetch only, instruction word returned next cycle
    cycle(1, 10'h004, 0, 0, 0, 0, 0, 32'h0);
    idle(32'h0000_0013);
    // load and fetch together: data first, fetch next
    cycle(1, 10'h008, 1, 0, 4'hF, 10'h020, 0, 32'h0);
    cycle(1, 10'h008, 0, 0, 0, 0, 0, 32'hCAFE_0001);
    idle(32'hCAFE_0002);
    // sustained data traffic starves fetch until the override kicks in
    for (int i = 0; i < 6; i++) cycle(1, 10'h00C, 1, 0, 4'hF, 10'(i), 0, $urandom);
    idle($urandom);
    // store: acknowledge carries zero data
    cycle(0, 0, 1, 1, 4'b0011, 10'h010, 32'hDEAD_BEEF, 32'h0);
    idle(32'hFFFF_FFFF);
    // alternating fetch/load with back-to-back responses
    for (int i = 0; i < 8; i++) cycle(i % 2 == 0, 10'(i), i % 2 == 1, 0, 4'hF, 10'(i + 16), 0, $urandom);
    idle($urandom);
    // reset the cycle after a grant drops the in-flight response
    cycle(1, 10'h044, 0, 0, 0, 0, 0, 32'h0);
    if_req_i = 1; d_req_i = 1; mem_rdata_i = 32'h7777_7777;
    rst_ni = 0;
    #1 chk_reset_outputs("rst_inflight");
    @(posedge clk_i);
    @(negedge clk_i);
    if_req_i = 0; d_req_i = 0;
    rst_ni = 1;
    starve = 0; resp = 0; resp_we = 0;
    idle(32'h8888_8888);
    idle(32'h9999_9999);
    // random traffic
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 2) != 0, 10'($urandom), $urandom_range(0, 2) != 0, 1'($urandom),
            4'($urandom), 10'($urandom), $urandom, $urandom);
    idle($urandom);
    idle($urandom);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
